// File: rtl/l1_trig_register.sv
// L1 trigger register: a FIFO that tags each accepted trigger with {L1ID, BCID}.
// Defining L1_REG_TMR_EN triplicates every state register behind a 2-of-3 vote.
module l1_trig_register #(
   parameter int DEPTH_LOG2 = 4,
   parameter int BCID_W     = 8,
   parameter int L1ID_W     = 4
) (
   input  logic                     Clk,
   input  logic                     Reset,
   input  logic                     TrigOut,
   input  logic                     BCR,
   input  logic                     ECR,
   input  logic                     Rd_Req,
   output logic [L1ID_W+BCID_W-1:0] Rd_Data,
   output logic                     Rd_Valid,
   output logic                     Empty,
   output logic                     L1_Reg_Full,
   output logic                     Overflow
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int DW    = L1ID_W + BCID_W;

   localparam logic [BCID_W-1:0]     BCID_ONE = {{(BCID_W-1){1'b0}}, 1'b1};
   localparam logic [L1ID_W-1:0]     L1ID_ONE = {{(L1ID_W-1){1'b0}}, 1'b1};
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
   localparam logic [DEPTH_LOG2:0]   OCC_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
   localparam logic [DEPTH_LOG2:0]   OCC_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

   typedef struct packed {
      logic [BCID_W-1:0]     bcid;
      logic [L1ID_W-1:0]     l1id;
      logic                  trig_prev;
      logic [DEPTH_LOG2-1:0] wr_ptr;
      logic [DEPTH_LOG2-1:0] rd_ptr;
      logic [DEPTH_LOG2:0]   occ;
      logic                  empty;
      logic                  full;
      logic                  ovf;
      logic [DW-1:0]         rd_data;
      logic                  rd_valid;
   } state_t;

   localparam state_t RESET_ST = '{
      bcid:      '0,
      l1id:      '1,
      trig_prev: 1'b0,
      wr_ptr:    '0,
      rd_ptr:    '0,
      occ:       '0,
      empty:     1'b1,
      full:      1'b0,
      ovf:       1'b0,
      rd_data:   '0,
      rd_valid:  1'b0
   };

   logic [DW-1:0]     mem_q [DEPTH];
   state_t            st_vote_s;
   state_t            st_d;
   logic              trig_rise_s;
   logic              wr_en_s;
   logic              rd_en_s;
   logic [L1ID_W-1:0] l1id_inc_s;

   // Next-state logic, always computed from the (voted) current state
   always_comb begin
      st_d        = st_vote_s;
      trig_rise_s = TrigOut & ~st_vote_s.trig_prev;
      wr_en_s     = TrigOut & ~ECR & ~st_vote_s.full;
      rd_en_s     = Rd_Req & ~ECR & ~st_vote_s.empty;

      if (trig_rise_s) begin
         l1id_inc_s = st_vote_s.l1id + L1ID_ONE;
      end else begin
         l1id_inc_s = st_vote_s.l1id;
      end

      if (BCR) begin
         st_d.bcid = '0;
      end else begin
         st_d.bcid = st_vote_s.bcid + BCID_ONE;
      end

      // ECR forces the next high cycle to count as a fresh burst
      st_d.trig_prev = TrigOut & ~ECR;
      st_d.rd_valid  = rd_en_s;

      if (rd_en_s) begin
         st_d.rd_data = mem_q[st_vote_s.rd_ptr];
         st_d.rd_ptr  = st_vote_s.rd_ptr + PTR_ONE;
      end else begin
         st_d.rd_data = st_vote_s.rd_data;
         st_d.rd_ptr  = st_vote_s.rd_ptr;
      end

      if (wr_en_s) begin
         st_d.wr_ptr = st_vote_s.wr_ptr + PTR_ONE;
      end else begin
         st_d.wr_ptr = st_vote_s.wr_ptr;
      end

      case ({wr_en_s, rd_en_s})
         2'b10:   st_d.occ = st_vote_s.occ + OCC_ONE;
         2'b01:   st_d.occ = st_vote_s.occ - OCC_ONE;
         default: st_d.occ = st_vote_s.occ;
      endcase

      if (ECR) begin
         st_d.l1id   = '1;
         st_d.wr_ptr = '0;
         st_d.rd_ptr = '0;
         st_d.occ    = '0;
         st_d.ovf    = 1'b0;
      end else begin
         st_d.l1id   = l1id_inc_s;
         st_d.ovf    = st_vote_s.ovf | (TrigOut & st_vote_s.full);
      end

      st_d.empty = (st_d.occ == '0);
      st_d.full  = (st_d.occ == OCC_FULL);
   end

   // Trigger storage; left without reset since the pointers define validity
   always_ff @(posedge Clk) begin
      if (wr_en_s) begin
         mem_q[st_vote_s.wr_ptr] <= {l1id_inc_s, st_vote_s.bcid};
      end
   end

`ifdef L1_REG_TMR_EN
   state_t st_q [3];

   function automatic state_t vote3(input state_t a, input state_t b, input state_t c);
      vote3 = state_t'((a & b) | (a & c) | (b & c));
   endfunction

   assign st_vote_s = vote3(st_q[0], st_q[1], st_q[2]);

   // All three copies reload from the vote, so a single upset heals in one edge
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         for (int i = 0; i < 3; i++) begin
            st_q[i] <= RESET_ST;
         end
      end else begin
         for (int i = 0; i < 3; i++) begin
            st_q[i] <= st_d;
         end
      end
   end
`else
   state_t st_q;

   assign st_vote_s = st_q;

   // Single-copy state register
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         st_q <= RESET_ST;
      end else begin
         st_q <= st_d;
      end
   end
`endif

   assign Rd_Data     = st_vote_s.rd_data;
   assign Rd_Valid    = st_vote_s.rd_valid;
   assign Empty       = st_vote_s.empty;
   assign L1_Reg_Full = st_vote_s.full;
   assign Overflow    = st_vote_s.ovf;

endmodule
